// File: rtl/term_rx_sequencer.sv
// ============================================================================
// Module      : term_rx_sequencer
// Description : Queues received UART bytes and turns them into text-buffer
//               writes, cursor moves, scroll requests and line clears.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module term_rx_sequencer #(
    parameter int COLS       = 80,
    parameter int ROWS       = 30,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                      clk100,
    input  logic                      reset,
    input  logic [7:0]                rx_data,
    input  logic                      rx_complete,
    output logic                      wr_en,
    input  logic                      wr_ready,
    output logic [$clog2(COLS)-1:0]   wr_col,
    output logic [$clog2(ROWS)-1:0]   wr_row,
    output logic [7:0]                wr_char,
    output logic                      scroll_req,
    input  logic                      scroll_ack,
    output logic [$clog2(COLS)-1:0]   cursor_col,
    output logic [$clog2(ROWS)-1:0]   cursor_row,
    output logic                      overflow
);

    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam int AW = $clog2(FIFO_DEPTH);

    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [7:0]    COL_MAX8 = 8'(COLS - 1);
    localparam logic [7:0]    ROW_MAX8 = 8'(ROWS - 1);
    localparam logic [AW:0]   DEPTH_C  = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_WRITE  = 3'd1,
        S_ESC    = 3'd2,
        S_CSI    = 3'd3,
        S_SCROLL = 3'd4,
        S_CLEAR  = 3'd5
    } state_t;

    // ------------------------------------------------------------------
    // Input byte FIFO, pushed on the rising edge of rx_complete
    // ------------------------------------------------------------------
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW:0]   count;
    logic          rx_prev;
    logic          push_req;
    logic          push_ok;
    logic          pop;
    logic          empty;
    logic          full;
    logic [7:0]    fbyte;

    assign empty    = (count == '0);
    assign full     = (count == DEPTH_C);
    assign push_req = rx_complete & ~rx_prev;
    // A pop in the same cycle frees a slot, so a push on a full FIFO still lands.
    assign push_ok  = push_req & (~full | pop);
    assign fbyte    = mem[rptr];

    always_ff @(posedge clk100) begin
        if (reset) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            rx_prev  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            rx_prev <= rx_complete;
            if (push_ok) begin
                mem[wptr] <= rx_data;
                wptr      <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    state_t        state, state_nxt;
    logic [CW-1:0] col_nxt;
    logic [RW-1:0] row_nxt;
    logic [CW-1:0] wr_col_nxt;
    logic [RW-1:0] wr_row_nxt;
    logic [7:0]    wr_char_nxt;
    logic [7:0]    p0, p1, p0_nxt, p1_nxt;
    logic          pidx, pidx_nxt;

    logic [7:0]    p_sel;
    logic [11:0]   digit_acc;
    logic [7:0]    p_sat;
    logic [7:0]    h_row8;
    logic [7:0]    h_col8;
    logic          last_col;
    logic          last_row;

    assign p_sel     = pidx ? p1 : p0;
    assign digit_acc = {4'd0, p_sel} * 12'd10 + {8'd0, fbyte[3:0]};
    assign p_sat     = (digit_acc > 12'd255) ? 8'hFF : digit_acc[7:0];
    // Position parameters are 1-based; zero is treated as one.
    assign h_row8    = (p0 == 8'd0) ? 8'd0 : p0 - 8'd1;
    assign h_col8    = (p1 == 8'd0) ? 8'd0 : p1 - 8'd1;
    assign last_col  = (cursor_col == COL_LAST);
    assign last_row  = (cursor_row == ROW_LAST);

    assign wr_en      = (state == S_WRITE) || (state == S_CLEAR);
    assign scroll_req = (state == S_SCROLL);

    always_ff @(posedge clk100) begin
        if (reset) begin
            state      <= S_IDLE;
            cursor_col <= '0;
            cursor_row <= '0;
            wr_col     <= '0;
            wr_row     <= '0;
            wr_char    <= 8'd0;
            p0         <= 8'd0;
            p1         <= 8'd0;
            pidx       <= 1'b0;
        end else begin
            state      <= state_nxt;
            cursor_col <= col_nxt;
            cursor_row <= row_nxt;
            wr_col     <= wr_col_nxt;
            wr_row     <= wr_row_nxt;
            wr_char    <= wr_char_nxt;
            p0         <= p0_nxt;
            p1         <= p1_nxt;
            pidx       <= pidx_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        col_nxt     = cursor_col;
        row_nxt     = cursor_row;
        wr_col_nxt  = wr_col;
        wr_row_nxt  = wr_row;
        wr_char_nxt = wr_char;
        p0_nxt      = p0;
        p1_nxt      = p1;
        pidx_nxt    = pidx;
        pop         = 1'b0;

        case (state)
            S_IDLE: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (fbyte >= 8'h20 && fbyte <= 8'h7E) begin
                        state_nxt   = S_WRITE;
                        wr_col_nxt  = cursor_col;
                        wr_row_nxt  = cursor_row;
                        wr_char_nxt = fbyte;
                    end else begin
                        case (fbyte)
                            8'h0A: begin
                                if (last_row) state_nxt = S_SCROLL;
                                else          row_nxt   = cursor_row + RW'(1);
                            end
                            8'h0D: col_nxt = '0;
                            8'h08: begin
                                if (cursor_col != '0) col_nxt = cursor_col - CW'(1);
                            end
                            8'h1B: state_nxt = S_ESC;
                            default: ;
                        endcase
                    end
                end
            end

            S_WRITE: begin
                if (wr_ready) begin
                    state_nxt = S_IDLE;
                    if (last_col) begin
                        col_nxt = '0;
                        if (last_row) state_nxt = S_SCROLL;
                        else          row_nxt   = cursor_row + RW'(1);
                    end else begin
                        col_nxt = cursor_col + CW'(1);
                    end
                end
            end

            S_ESC: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (fbyte == 8'h5B) begin
                        state_nxt = S_CSI;
                        p0_nxt    = 8'd0;
                        p1_nxt    = 8'd0;
                        pidx_nxt  = 1'b0;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end

            S_CSI: begin
                if (!empty) begin
                    pop = 1'b1;
                    if (fbyte >= 8'h30 && fbyte <= 8'h39) begin
                        if (pidx) p1_nxt = p_sat;
                        else      p0_nxt = p_sat;
                    end else if (fbyte == 8'h3B) begin
                        pidx_nxt = 1'b1;
                    end else if (fbyte == 8'h48) begin
                        row_nxt   = (h_row8 > ROW_MAX8) ? ROW_LAST : h_row8[RW-1:0];
                        col_nxt   = (h_col8 > COL_MAX8) ? COL_LAST : h_col8[CW-1:0];
                        state_nxt = S_IDLE;
                    end else if (fbyte == 8'h4B) begin
                        state_nxt   = S_CLEAR;
                        wr_col_nxt  = cursor_col;
                        wr_row_nxt  = cursor_row;
                        wr_char_nxt = 8'h20;
                    end else begin
                        state_nxt = S_IDLE;
                    end
                end
            end

            S_SCROLL: begin
                if (scroll_ack) begin
                    state_nxt   = S_CLEAR;
                    wr_col_nxt  = '0;
                    wr_row_nxt  = ROW_LAST;
                    wr_char_nxt = 8'h20;
                end
            end

            S_CLEAR: begin
                if (wr_ready) begin
                    if (wr_col == COL_LAST) state_nxt  = S_IDLE;
                    else                    wr_col_nxt = wr_col + CW'(1);
                end
            end

            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

`default_nettype wire

// File: tb/tb_term_rx_sequencer.sv
// ============================================================================
// Module      : tb_term_rx_sequencer
// Description : Directed, table-driven self-checking bench for term_rx_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_term_rx_sequencer;

    logic       clk100 = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rx_complete;
    logic       wr_en;
    logic       wr_ready;
    logic [6:0] wr_col;
    logic [4:0] wr_row;
    logic [7:0] wr_char;
    logic       scroll_req;
    logic       scroll_ack;
    logic [6:0] cursor_col;
    logic [4:0] cursor_row;
    logic       overflow;

    term_rx_sequencer #(.COLS(80), .ROWS(30), .FIFO_DEPTH(4)) dut (
        .clk100      (clk100),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_complete (rx_complete),
        .wr_en       (wr_en),
        .wr_ready    (wr_ready),
        .wr_col      (wr_col),
        .wr_row      (wr_row),
        .wr_char     (wr_char),
        .scroll_req  (scroll_req),
        .scroll_ack  (scroll_ack),
        .cursor_col  (cursor_col),
        .cursor_row  (cursor_row),
        .overflow    (overflow)
    );

    always #5 clk100 = ~clk100;

    int errors = 0;
    int checks = 0;

    // Log of every accepted write, captured mid-cycle
    int         wcount = 0;
    logic [6:0] log_col [1024];
    logic [4:0] log_row [1024];
    logic [7:0] log_chr [1024];

    always @(negedge clk100) begin
        if (!reset && wr_en && wr_ready && wcount < 1024) begin
            log_col[wcount] = wr_col;
            log_row[wcount] = wr_row;
            log_chr[wcount] = wr_char;
            wcount = wcount + 1;
        end
    end

    typedef struct {
        logic [7:0] b;
        int         nw;
        int         wc;
        int         wr;
        int         cr;
        int         cc;
    } vec_t;

    vec_t vt [64];
    int   nv = 0;

    task automatic add(input logic [7:0] b, input int nw, input int wc, input int wr,
                       input int cr, input int cc);
        vt[nv].b  = b;
        vt[nv].nw = nw;
        vt[nv].wc = wc;
        vt[nv].wr = wr;
        vt[nv].cr = cr;
        vt[nv].cc = cc;
        nv = nv + 1;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk100);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data     = b;
        rx_complete = 1'b1;
        tick();
        rx_complete = 1'b0;
        tick();
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        rx_complete = 1'b0;
        scroll_ack  = 1'b0;
        ticks(2);
        reset = 1'b0;
    endtask

    initial begin
        int base;
        int t;
        int bad;

        reset       = 1'b1;
        rx_data     = 8'h00;
        rx_complete = 1'b0;
        wr_ready    = 1'b1;
        scroll_ack  = 1'b0;

        // Byte, writes expected, write col/row, resulting cursor row/col
        add("A",   1,  0, 0,  0,  1);
        add("B",   1,  1, 0,  0,  2);
        add(8'h08, 0,  0, 0,  0,  1);
        add(8'h0D, 0,  0, 0,  0,  0);
        add(8'h08, 0,  0, 0,  0,  0);
        add(8'h0A, 0,  0, 0,  1,  0);
        add(8'h07, 0,  0, 0,  1,  0);
        add(8'h1B, 0,  0, 0,  1,  0);
        add("[",   0,  0, 0,  1,  0);
        add("5",   0,  0, 0,  1,  0);
        add(";",   0,  0, 0,  1,  0);
        add("1",   0,  0, 0,  1,  0);
        add("0",   0,  0, 0,  1,  0);
        add("H",   0,  0, 0,  4,  9);
        add("Z",   1,  9, 4,  4, 10);
        add(8'h1B, 0,  0, 0,  4, 10);
        add("[",   0,  0, 0,  4, 10);
        add("0",   0,  0, 0,  4, 10);
        add(";",   0,  0, 0,  4, 10);
        add("2",   0,  0, 0,  4, 10);
        add("0",   0,  0, 0,  4, 10);
        add("0",   0,  0, 0,  4, 10);
        add("H",   0,  0, 0,  0, 79);
        add(8'h1B, 0,  0, 0,  0, 79);
        add("Q",   0,  0, 0,  0, 79);
        add("Y",   1, 79, 0,  1,  0);
        add(8'h1B, 0,  0, 0,  1,  0);
        add("[",   0,  0, 0,  1,  0);
        add("9",   0,  0, 0,  1,  0);
        add("9",   0,  0, 0,  1,  0);
        add("9",   0,  0, 0,  1,  0);
        add(";",   0,  0, 0,  1,  0);
        add("9",   0,  0, 0,  1,  0);
        add("9",   0,  0, 0,  1,  0);
        add("9",   0,  0, 0,  1,  0);
        add("H",   0,  0, 0, 29, 79);
        add(8'h1B, 0,  0, 0, 29, 79);
        add("[",   0,  0, 0, 29, 79);
        add("3",   0,  0, 0, 29, 79);
        add(";",   0,  0, 0, 29, 79);
        add(";",   0,  0, 0, 29, 79);
        add("5",   0,  0, 0, 29, 79);
        add("H",   0,  0, 0,  2,  4);
        add(8'h1B, 0,  0, 0,  2,  4);
        add("[",   0,  0, 0,  2,  4);
        add("H",   0,  0, 0,  0,  0);
        add(8'h1B, 0,  0, 0,  0,  0);
        add("[",   0,  0, 0,  0,  0);
        add("7",   0,  0, 0,  0,  0);
        add("q",   0,  0, 0,  0,  0);
        add("j",   1,  0, 0,  0,  1);
        add(8'h7F, 0,  0, 0,  0,  1);
        add("~",   1,  1, 0,  0,  2);
        add(8'h20, 1,  2, 0,  0,  3);
        add(8'h1F, 0,  0, 0,  0,  3);

        do_reset();
        chk("reset_wr_en",      wr_en,      0);
        chk("reset_scroll_req", scroll_req, 0);
        chk("reset_wr_col",     wr_col,     0);
        chk("reset_wr_row",     wr_row,     0);
        chk("reset_wr_char",    wr_char,    0);
        chk("reset_cursor_col", cursor_col, 0);
        chk("reset_cursor_row", cursor_row, 0);
        chk("reset_overflow",   overflow,   0);

        for (int i = 0; i < nv; i++) begin
            base = wcount;
            send_byte(vt[i].b);
            ticks(4);
            chk($sformatf("vec%0d_writes", i), wcount - base, vt[i].nw);
            if (vt[i].nw == 1 && wcount > base) begin
                chk($sformatf("vec%0d_wr_col", i),  log_col[base], vt[i].wc);
                chk($sformatf("vec%0d_wr_row", i),  log_row[base], vt[i].wr);
                chk($sformatf("vec%0d_wr_char", i), log_chr[base], vt[i].b);
            end
            chk($sformatf("vec%0d_cursor_row", i), cursor_row, vt[i].cr);
            chk($sformatf("vec%0d_cursor_col", i), cursor_col, vt[i].cc);
        end

        // Push-to-write latency
        do_reset();
        rx_data     = "A";
        rx_complete = 1'b1;
        tick();
        rx_complete = 1'b0;
        chk("lat_n1_wr_en", wr_en, 0);
        tick();
        chk("lat_n2_wr_en",   wr_en,   1);
        chk("lat_n2_wr_col",  wr_col,  0);
        chk("lat_n2_wr_row",  wr_row,  0);
        chk("lat_n2_wr_char", wr_char, 8'h41);
        tick();
        chk("lat_n3_cursor_col", cursor_col, 1);
        chk("lat_n3_wr_en",      wr_en,      0);

        // Held rx_complete level pushes once
        base        = wcount;
        rx_data     = "C";
        rx_complete = 1'b1;
        ticks(20);
        rx_complete = 1'b0;
        ticks(10);
        chk("held_writes", wcount - base, 1);
        if (wcount > base) begin
            chk("held_char", log_chr[base], 8'h43);
            chk("held_col",  log_col[base], 1);
        end
        chk("held_cursor_col", cursor_col, 2);

        // Bottom-right wrap triggers scroll and last-row clear
        do_reset();
        send_byte(8'h1B); send_byte("["); send_byte("3"); send_byte("0");
        send_byte(";");   send_byte("8"); send_byte("0"); send_byte("H");
        ticks(2);
        chk("scr_pre_row", cursor_row, 29);
        chk("scr_pre_col", cursor_col, 79);
        base = wcount;
        send_byte("X");
        t = 0;
        while (!scroll_req && t < 20) begin
            tick();
            t = t + 1;
        end
        chk("scr_req_rise", scroll_req, 1);
        ticks(5);
        chk("scr_req_held", scroll_req, 1);
        chk("scr_x_writes", wcount - base, 1);
        if (wcount > base) begin
            chk("scr_x_col",  log_col[base], 79);
            chk("scr_x_row",  log_row[base], 29);
            chk("scr_x_char", log_chr[base], 8'h58);
        end
        chk("scr_cursor_row", cursor_row, 29);
        chk("scr_cursor_col", cursor_col, 0);
        scroll_ack = 1'b1;
        tick();
        scroll_ack = 1'b0;
        t = 0;
        while (wcount - base < 81 && t < 300) begin
            tick();
            t = t + 1;
        end
        ticks(3);
        chk("scr_total_writes", wcount - base, 81);
        bad = 0;
        for (int k = 0; k < 80; k++) begin
            if (base + 1 + k < wcount) begin
                if (log_row[base+1+k] != 5'd29 || log_col[base+1+k] != 7'(k) ||
                    log_chr[base+1+k] != 8'h20)
                    bad = bad + 1;
            end
        end
        chk("scr_clear_entries_bad", bad, 0);
        chk("scr_req_done", scroll_req, 0);
        chk("scr_post_row", cursor_row, 29);
        chk("scr_post_col", cursor_col, 0);
        base = wcount;
        scroll_ack = 1'b1;
        tick();
        scroll_ack = 1'b0;
        ticks(5);
        chk("stray_ack_writes", wcount - base, 0);
        chk("stray_ack_req",    scroll_req,    0);

        // Back-pressure: stalled write, full FIFO, overflow
        do_reset();
        wr_ready = 1'b0;
        base = wcount;
        for (int k = 0; k < 6; k++) send_byte(8'h61 + 8'(k));
        bad = 0;
        for (int k = 0; k < 88; k++) begin
            if (!(wr_en && wr_char == 8'h61 && wr_col == 7'd0 && wr_row == 5'd0))
                bad = bad + 1;
            tick();
        end
        chk("stall_unstable_cycles", bad, 0);
        chk("stall_writes", wcount - base, 0);
        chk("stall_overflow", overflow, 1);
        wr_ready = 1'b1;
        ticks(20);
        chk("release_writes", wcount - base, 5);
        for (int k = 0; k < 5; k++) begin
            if (base + k < wcount) begin
                chk($sformatf("release%0d_char", k), log_chr[base+k], 8'h61 + k);
                chk($sformatf("release%0d_col", k),  log_col[base+k], k);
            end
        end
        chk("release_cursor_col", cursor_col, 5);
        chk("release_overflow",   overflow,   1);

        // Reset in the middle of an erase-to-end-of-line
        base = wcount;
        send_byte(8'h1B); send_byte("["); send_byte("K");
        rx_data     = "Q";
        rx_complete = 1'b1;
        tick();
        rx_complete = 1'b0;
        tick();
        chk("clr_active", wr_en, 1);
        if (wcount > base) begin
            chk("clr_first_col",  log_col[base], 5);
            chk("clr_first_char", log_chr[base], 8'h20);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_mid_wr_en",      wr_en,      0);
        chk("rst_mid_cursor_col", cursor_col, 0);
        chk("rst_mid_cursor_row", cursor_row, 0);
        chk("rst_mid_overflow",   overflow,   0);
        base = wcount;
        ticks(6);
        chk("rst_mid_fifo_empty", wcount - base, 0);
        send_byte("B");
        ticks(4);
        chk("post_rst_writes", wcount - base, 1);
        if (wcount > base) begin
            chk("post_rst_col",  log_col[base], 0);
            chk("post_rst_row",  log_row[base], 0);
            chk("post_rst_char", log_chr[base], 8'h42);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
